// File: rtl/countdown_ctrl_if.sv
// Control and status bundle between countdown_ctrl and the mm:ss BCD digit chain.
// All signals are level-sampled on the rising clock edge; there is no valid/ready
// handshake, a request simply takes effect in the cycle it is seen high.
interface countdown_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       load_req;
  logic       door_open;
  logic       chain_zero;
  logic       loadn;
  logic       chain_clrn;
  logic       cnt_en;
  logic       running;
  logic       done;
  logic       beep;
  logic [2:0] state;

  modport slave (
    input  start, stop, clear, load_req, door_open, chain_zero,
    output loadn, chain_clrn, cnt_en, running, done, beep, state
  );

  modport master (
    output start, stop, clear, load_req, door_open, chain_zero,
    input  loadn, chain_clrn, cnt_en, running, done, beep, state
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Sequencer for the mm:ss countdown chain: load/clear strobes, one-per-tick
// count enable from a prescaler, run/pause/done FSM with door interlock and beeper.
module countdown_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int BEEP_CYCLES = 100000000
) (
  input  logic               clock,
  input  logic               clrn,
  countdown_ctrl_if.slave    bus
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
  logic                chain_clrn_q, chain_clrn_d;
  logic                tick_last;

  assign tick_last = (div_q == DIV_W'(TICK_DIV - 1));

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    beep_cnt_d   = beep_cnt_q;
    chain_clrn_d = !bus.clear;

    case (state_q)
      IDLE: begin
        if (bus.load_req) state_d = LOAD;
      end
      LOAD: begin
        state_d = READY;
        div_d   = '0;
      end
      READY: begin
        if (bus.load_req) begin
          state_d = LOAD;
        end else if (bus.start && !bus.door_open && !bus.chain_zero) begin
          state_d = RUN;
          div_d   = '0;
        end
      end
      RUN: begin
        if (bus.stop || bus.door_open) begin
          state_d = PAUSE;
        end else if (bus.chain_zero) begin
          state_d    = DONE;
          beep_cnt_d = BEEP_W'(BEEP_CYCLES);
        end else begin
          div_d = tick_last ? '0 : div_q + DIV_W'(1);
        end
      end
      PAUSE: begin
        // Divider is left untouched so a resume finishes the partial second.
        if (bus.load_req) begin
          state_d = LOAD;
        end else if (bus.start && !bus.door_open) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.load_req) begin
          state_d = LOAD;
        end else if (bus.stop) begin
          beep_cnt_d = '0;
        end else if (beep_cnt_q != '0) begin
          beep_cnt_d = beep_cnt_q - BEEP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.clear) begin
      state_d = IDLE;
      div_d   = div_q;
    end

    // The beeper only sounds while the run is finished.
    if (state_d != DONE) beep_cnt_d = '0;
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      div_q        <= '0;
      beep_cnt_q   <= '0;
      chain_clrn_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      beep_cnt_q   <= beep_cnt_d;
      chain_clrn_q <= chain_clrn_d;
    end
  end

  assign bus.loadn      = (state_q != LOAD);
  assign bus.chain_clrn = chain_clrn_q;
  assign bus.running    = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.beep       = (beep_cnt_q != '0);
  assign bus.state      = state_q;
  assign bus.cnt_en     = (state_q == RUN) && tick_last && !bus.clear && !bus.stop &&
                          !bus.door_open && !bus.chain_zero;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with a 4-cycle tick and a 3-cycle beep.
module tb_countdown_ctrl;

  logic clock;
  logic clrn;
  int   compared;
  int   mismatched;

  countdown_ctrl_if bus ();

  countdown_ctrl #(
    .TICK_DIV    (4),
    .BEEP_CYCLES (3)
  ) dut (
    .clock (clock),
    .clrn  (clrn),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Driver: walk IDLE -> LOAD -> READY -> RUN with chain non-zero, door closed.
  task automatic drive_to_run();
    bus.load_req = 1'b1;
    cyc();
    bus.load_req   = 1'b0;
    bus.chain_zero = 1'b0;
    bus.door_open  = 1'b0;
    cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    clrn           = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.clear      = 1'b0;
    bus.load_req   = 1'b0;
    bus.door_open  = 1'b0;
    bus.chain_zero = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    compared++;
    if (bus.state !== 3'd0 || bus.loadn !== 1'b1 || bus.chain_clrn !== 1'b1 ||
        bus.cnt_en !== 1'b0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.beep !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got state=%0d loadn=%b clrn=%b en=%b run=%b done=%b beep=%b want 0 1 1 0 0 0 0",
               bus.state, bus.loadn, bus.chain_clrn, bus.cnt_en, bus.running, bus.done, bus.beep);
    end
    @(negedge clock);
    clrn = 1'b1;
    cyc();
  endtask

  task automatic test_run_ticks();
    logic exp;
    bus.load_req = 1'b1;
    cyc();
    bus.load_req = 1'b0;
    compared++;
    if (bus.state !== 3'd1 || bus.loadn !== 1'b0) begin
      mismatched++;
      $display("FAIL load_state: got state=%0d loadn=%b want 1 0", bus.state, bus.loadn);
    end
    cyc();
    compared++;
    if (bus.state !== 3'd2 || bus.loadn !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_after_load: got state=%0d loadn=%b want 2 1", bus.state, bus.loadn);
    end
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    #1;
    compared++;
    if (bus.state !== 3'd3 || bus.running !== 1'b1) begin
      mismatched++;
      $display("FAIL run_entry: got state=%0d running=%b want 3 1", bus.state, bus.running);
    end
    for (int i = 1; i <= 12; i++) begin
      exp = (i % 4 == 0);
      compared++;
      if (bus.cnt_en !== exp) begin
        mismatched++;
        $display("FAIL tick_cycle_%0d: got cnt_en=%b want %b", i, bus.cnt_en, exp);
      end
      cyc();
    end
  endtask

  task automatic test_pause_resume();
    cyc();
    cyc();
    bus.stop = 1'b1;
    #1;
    compared++;
    if (bus.cnt_en !== 1'b0) begin
      mismatched++;
      $display("FAIL stop_cycle_en: got %b want 0", bus.cnt_en);
    end
    cyc();
    bus.stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if (bus.state !== 3'd4 || bus.cnt_en !== 1'b0) begin
        mismatched++;
        $display("FAIL paused_%0d: got state=%0d cnt_en=%b want 4 0", i, bus.state, bus.cnt_en);
      end
      cyc();
    end
    bus.start = 1'b1;
    #1;
    compared++;
    if (bus.cnt_en !== 1'b0) begin
      mismatched++;
      $display("FAIL resume_req_en: got %b want 0", bus.cnt_en);
    end
    cyc();
    bus.start = 1'b0;
    #1;
    compared++;
    if (bus.state !== 3'd3 || bus.cnt_en !== 1'b0) begin
      mismatched++;
      $display("FAIL resume_first: got state=%0d cnt_en=%b want 3 0", bus.state, bus.cnt_en);
    end
    cyc();
    compared++;
    if (bus.cnt_en !== 1'b1) begin
      mismatched++;
      $display("FAIL resume_second: got cnt_en=%b want 1", bus.cnt_en);
    end
    cyc();
  endtask

  task automatic test_done_beep();
    logic exp;
    repeat (3) cyc();
    bus.chain_zero = 1'b1;
    #1;
    compared++;
    if (bus.cnt_en !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_on_tick_en: got %b want 0", bus.cnt_en);
    end
    cyc();
    bus.start = 1'b1;
    compared++;
    if (bus.state !== 3'd5 || bus.done !== 1'b1 || bus.running !== 1'b0) begin
      mismatched++;
      $display("FAIL done_entry: got state=%0d done=%b running=%b want 5 1 0", bus.state, bus.done, bus.running);
    end
    for (int i = 0; i < 5; i++) begin
      exp = (i < 3);
      #1;
      compared++;
      if (bus.beep !== exp || bus.cnt_en !== 1'b0 || bus.state !== 3'd5) begin
        mismatched++;
        $display("FAIL beep_cycle_%0d: got beep=%b cnt_en=%b state=%0d want %b 0 5",
                 i, bus.beep, bus.cnt_en, bus.state, exp);
      end
      cyc();
    end
    bus.start = 1'b0;
    drive_to_run();
    bus.chain_zero = 1'b1;
    cyc();
    compared++;
    if (bus.beep !== 1'b1) begin
      mismatched++;
      $display("FAIL beep_reentry: got %b want 1", bus.beep);
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    compared++;
    if (bus.beep !== 1'b0 || bus.state !== 3'd5) begin
      mismatched++;
      $display("FAIL stop_silences: got beep=%b state=%0d want 0 5", bus.beep, bus.state);
    end
  endtask

  task automatic test_interlock();
    bus.load_req = 1'b1;
    cyc();
    bus.load_req   = 1'b0;
    bus.chain_zero = 1'b0;
    cyc();
    bus.start     = 1'b1;
    bus.door_open = 1'b1;
    cyc();
    compared++;
    if (bus.state !== 3'd2) begin
      mismatched++;
      $display("FAIL ready_door_open: got state=%0d want 2", bus.state);
    end
    bus.door_open  = 1'b0;
    bus.chain_zero = 1'b1;
    cyc();
    compared++;
    if (bus.state !== 3'd2) begin
      mismatched++;
      $display("FAIL ready_chain_zero: got state=%0d want 2", bus.state);
    end
    bus.chain_zero = 1'b0;
    cyc();
    bus.start = 1'b0;
    compared++;
    if (bus.state !== 3'd3) begin
      mismatched++;
      $display("FAIL ready_to_run: got state=%0d want 3", bus.state);
    end
    bus.door_open = 1'b1;
    cyc();
    bus.door_open = 1'b0;
    compared++;
    if (bus.state !== 3'd4 || bus.running !== 1'b0) begin
      mismatched++;
      $display("FAIL door_pauses: got state=%0d running=%b want 4 0", bus.state, bus.running);
    end
  endtask

  task automatic test_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    compared++;
    if (bus.state !== 3'd0 || bus.chain_clrn !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_in_pause: got state=%0d chain_clrn=%b want 0 0", bus.state, bus.chain_clrn);
    end
    cyc();
    compared++;
    if (bus.chain_clrn !== 1'b1) begin
      mismatched++;
      $display("FAIL clear_pulse_width: got chain_clrn=%b want 1", bus.chain_clrn);
    end
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    compared++;
    if (bus.state !== 3'd0 || bus.chain_clrn !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_in_idle: got state=%0d chain_clrn=%b want 0 0", bus.state, bus.chain_clrn);
    end
    drive_to_run();
    repeat (3) cyc();
    bus.clear = 1'b1;
    bus.start = 1'b1;
    #1;
    compared++;
    if (bus.cnt_en !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_masks_tick: got cnt_en=%b want 0", bus.cnt_en);
    end
    cyc();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    compared++;
    if (bus.state !== 3'd0 || bus.running !== 1'b0 || bus.chain_clrn !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_in_run: got state=%0d running=%b chain_clrn=%b want 0 0 0",
               bus.state, bus.running, bus.chain_clrn);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    drive_to_run();
    repeat (3) cyc();
    #1;
    compared++;
    if (bus.cnt_en !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_reset_tick: got cnt_en=%b want 1", bus.cnt_en);
    end
    #1;
    clrn = 1'b0;
    #1;
    compared++;
    if (bus.state !== 3'd0 || bus.running !== 1'b0 || bus.cnt_en !== 1'b0 || bus.loadn !== 1'b1) begin
      mismatched++;
      $display("FAIL async_reset: got state=%0d running=%b cnt_en=%b loadn=%b want 0 0 0 1",
               bus.state, bus.running, bus.cnt_en, bus.loadn);
    end
    #1;
    clrn      = 1'b1;
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      compared++;
      if (bus.state !== 3'd0) begin
        mismatched++;
        $display("FAIL start_after_reset_%0d: got state=%0d want 0", i, bus.state);
      end
    end
    bus.start    = 1'b0;
    bus.load_req = 1'b1;
    cyc();
    bus.load_req = 1'b0;
    cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    compared++;
    if (bus.state !== 3'd3) begin
      mismatched++;
      $display("FAIL run_after_load: got state=%0d want 3", bus.state);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_run_ticks();
    test_pause_resume();
    test_done_beep();
    test_interlock();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
